// File: rtl/onewire_pkg.sv
// Shared definitions for the 1-Wire master: timing defaults, ROM/function command
// bytes, bus-driver mux encodings and the temperature sequencer state set.
package onewire_pkg;

    localparam int unsigned DEF_CYCLES_PER_US = 27;
    localparam int unsigned DEF_CONV_WAIT_US  = 750000;

    localparam logic [7:0] DEF_CMD_SKIP_ROM = 8'hCC;
    localparam logic [7:0] DEF_CMD_CONVERT  = 8'h44;
    localparam logic [7:0] DEF_CMD_READ_SP  = 8'hBE;

    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_RST  = 2'd1;
    localparam logic [1:0] BUS_WR   = 2'd2;
    localparam logic [1:0] BUS_RD   = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RST1,
        ST_SKIP1,
        ST_CONV,
        ST_WAITC,
        ST_RST2,
        ST_SKIP2,
        ST_RDSP,
        ST_RDLSB,
        ST_RDMSB
    } state_t;

    typedef enum logic {
        HS_RUN,
        HS_REL
    } hs_phase_t;

    // Which slot engine owns the bus in a given sequencer state.
    function automatic logic [1:0] step_bus(input state_t s);
        case (s)
            ST_RST1, ST_RST2:                     return BUS_RST;
            ST_SKIP1, ST_CONV, ST_SKIP2, ST_RDSP: return BUS_WR;
            ST_RDLSB, ST_RDMSB:                   return BUS_RD;
            default:                              return BUS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/onewire_step_hs.sv
// Generic enable/done handshake for one slot-engine step: enable until done is seen,
// then hold off in a release phase until the engine drops done again.
module onewire_step_hs
    import onewire_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic done,
    output logic en,
    output logic done_seen,
    output logic complete
);

    hs_phase_t phase, phase_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase <= HS_RUN;
        end else begin
            phase <= phase_next;
        end
    end

    always_comb begin
        phase_next = phase;
        if (!active) begin
            phase_next = HS_RUN;
        end else if (phase == HS_RUN && done) begin
            phase_next = HS_REL;
        end else if (phase == HS_REL && !done) begin
            phase_next = HS_RUN;
        end
    end

    // Completion re-arms the run phase, so the following step enables on its first cycle.
    always_comb begin
        en        = active && (phase == HS_RUN);
        done_seen = en && done;
        complete  = active && (phase == HS_REL) && !done;
    end

endmodule

// File: rtl/onewire_temp_sequencer.sv
// Single-drop 1-Wire temperature read: reset, SKIP ROM, CONVERT T, conversion wait,
// reset, SKIP ROM, READ SCRATCHPAD, two read bytes assembled into temp.
module onewire_temp_sequencer
    import onewire_pkg::*;
#(
    parameter int unsigned CYCLES_PER_US = DEF_CYCLES_PER_US,
    parameter int unsigned CONV_WAIT_US  = DEF_CONV_WAIT_US,
    parameter logic [7:0]  CMD_SKIP_ROM  = DEF_CMD_SKIP_ROM,
    parameter logic [7:0]  CMD_CONVERT   = DEF_CMD_CONVERT,
    parameter logic [7:0]  CMD_READ_SP   = DEF_CMD_READ_SP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        temp_valid,
    output logic [15:0] temp,
    output logic        presence_err,
    output logic [1:0]  bus_sel,
    output logic        rst_en,
    input  logic        rst_done,
    input  logic        rst_presence,
    output logic        wr_en,
    output logic [7:0]  wr_byte,
    input  logic        wr_done,
    output logic        rd_en,
    input  logic        rd_done,
    input  logic        rd_sample,
    input  logic        ow_in
);

    localparam int unsigned WAIT_CYCLES = CONV_WAIT_US * CYCLES_PER_US;
    localparam int unsigned WAIT_W      = $clog2(WAIT_CYCLES) + 1;

    state_t            state, state_next;
    logic [1:0]        bus_cur;
    logic              step_active, step_done, in_read;
    logic              hs_en, hs_done_seen, hs_complete;
    logic [WAIT_W-1:0] wait_cnt;
    logic [7:0]        sh;
    logic [3:0]        bit_cnt;
    logic [15:0]       stage;

    onewire_step_hs u_step_hs (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (step_active),
        .done      (step_done),
        .en        (hs_en),
        .done_seen (hs_done_seen),
        .complete  (hs_complete)
    );

    always_comb begin
        bus_cur     = step_bus(state);
        step_active = (bus_cur != BUS_NONE);
        in_read     = (bus_cur == BUS_RD);
        case (bus_cur)
            BUS_RST: step_done = rst_done;
            BUS_WR:  step_done = wr_done;
            BUS_RD:  step_done = rd_done;
            default: step_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // presence_err is already updated when the reset step completes, so it picks the exit.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start)       state_next = ST_RST1;
            ST_RST1:  if (hs_complete) state_next = presence_err ? ST_IDLE : ST_SKIP1;
            ST_SKIP1: if (hs_complete) state_next = ST_CONV;
            ST_CONV:  if (hs_complete) state_next = ST_WAITC;
            ST_WAITC: if (wait_cnt == WAIT_W'(WAIT_CYCLES - 1)) state_next = ST_RST2;
            ST_RST2:  if (hs_complete) state_next = presence_err ? ST_IDLE : ST_SKIP2;
            ST_SKIP2: if (hs_complete) state_next = ST_RDSP;
            ST_RDSP:  if (hs_complete) state_next = ST_RDLSB;
            ST_RDLSB: if (hs_complete) state_next = ST_RDMSB;
            ST_RDMSB: if (hs_complete) state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_sel = bus_cur;
        rst_en  = hs_en && (bus_cur == BUS_RST);
        wr_en   = hs_en && (bus_cur == BUS_WR);
        rd_en   = hs_en && (bus_cur == BUS_RD);
        busy    = (state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            temp         <= '0;
            temp_valid   <= 1'b0;
            presence_err <= 1'b0;
            wr_byte      <= '0;
            sh           <= '0;
            bit_cnt      <= '0;
            stage        <= '0;
            wait_cnt     <= '0;
        end else begin
            temp_valid <= 1'b0;
            if (state == ST_IDLE && start) begin
                presence_err <= 1'b0;
            end else if (hs_done_seen && bus_cur == BUS_RST && !rst_presence) begin
                presence_err <= 1'b1;
            end
            wait_cnt <= (state == ST_WAITC) ? wait_cnt + 1'b1 : '0;
            if (state_next != state) begin
                sh      <= '0;
                bit_cnt <= '0;
            end else if (in_read && rd_sample) begin
                sh      <= {ow_in, sh[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (hs_done_seen && state == ST_RDLSB) stage[7:0]  <= sh;
            if (hs_done_seen && state == ST_RDMSB) stage[15:8] <= sh;
            if (hs_complete && state == ST_RDMSB) begin
                temp       <= stage;
                temp_valid <= 1'b1;
            end
            if (state_next != state) begin
                case (state_next)
                    ST_SKIP1, ST_SKIP2: wr_byte <= CMD_SKIP_ROM;
                    ST_CONV:            wr_byte <= CMD_CONVERT;
                    ST_RDSP:            wr_byte <= CMD_READ_SP;
                    default:            ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_onewire_temp_sequencer.sv
// Bench for onewire_temp_sequencer: slot engines modelled here, outputs checked each
// cycle against a step-queue transaction model plus literal expectations.
module tb_onewire_temp_sequencer;

    localparam int ENG_LAT  = 20;
    localparam int WAIT_LEN = 54;

    logic        clk, rst_n, start;
    logic        busy, temp_valid, presence_err;
    logic [15:0] temp;
    logic [1:0]  bus_sel;
    logic        rst_en, rst_done, rst_presence;
    logic        wr_en, wr_done;
    logic [7:0]  wr_byte;
    logic        rd_en, rd_done, rd_sample, ow_in;

    int n_checks = 0;
    int n_fail   = 0;

    logic       cfg_presence;
    int         cfg_wr_hold;
    logic       noise_en;
    logic [7:0] cfg_lsb, cfg_msb;
    logic [7:0] rd_q[$];
    logic [7:0] wr_log[$];
    int         valid_cnt, last_wait, wait_run;

    onewire_temp_sequencer #(.CONV_WAIT_US(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .temp_valid   (temp_valid),
        .temp         (temp),
        .presence_err (presence_err),
        .bus_sel      (bus_sel),
        .rst_en       (rst_en),
        .rst_done     (rst_done),
        .rst_presence (rst_presence),
        .wr_en        (wr_en),
        .wr_byte      (wr_byte),
        .wr_done      (wr_done),
        .rd_en        (rd_en),
        .rd_done      (rd_done),
        .rd_sample    (rd_sample),
        .ow_in        (ow_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Engines update on the falling edge so the DUT sees stable inputs at the rising edge.
    initial begin : eng_rst
        int cnt;
        cnt = 0;
        rst_done = 1'b0;
        rst_presence = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_en) begin
                cnt++;
                if (cnt == ENG_LAT) begin
                    rst_done = 1'b1;
                    rst_presence = cfg_presence;
                end
            end else begin
                cnt = 0;
                rst_done = 1'b0;
                rst_presence = 1'b0;
            end
        end
    end

    initial begin : eng_wr
        int   cnt, hold;
        logic prev_en;
        cnt = 0;
        hold = 0;
        prev_en = 1'b0;
        wr_done = 1'b0;
        forever begin
            @(negedge clk);
            if (wr_en) begin
                if (!prev_en) wr_log.push_back(wr_byte);
                cnt++;
                if (cnt == ENG_LAT) begin
                    wr_done = 1'b1;
                    hold = cfg_wr_hold;
                end
            end else begin
                cnt = 0;
                if (wr_done) begin
                    if (hold > 0) hold--;
                    else wr_done = 1'b0;
                end
            end
            prev_en = wr_en;
        end
    end

    initial begin : eng_rd
        int         cnt, bit_idx;
        logic [7:0] b;
        cnt = 0;
        b = 8'h00;
        rd_done = 1'b0;
        rd_sample = 1'b0;
        ow_in = 1'b0;
        forever begin
            @(negedge clk);
            rd_sample = 1'b0;
            ow_in = 1'($urandom_range(0, 1));
            if (rd_en) begin
                if (cnt == 0) b = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
                cnt++;
                if (cnt >= 2 && cnt <= 16 && (cnt % 2) == 0) begin
                    bit_idx = cnt / 2 - 1;
                    rd_sample = 1'b1;
                    ow_in = b[bit_idx];
                end
                if (cnt == ENG_LAT) rd_done = 1'b1;
            end else begin
                cnt = 0;
                rd_done = 1'b0;
                if (noise_en && busy && bus_sel == 2'd0) rd_sample = 1'($urandom_range(0, 1));
            end
        end
    end

    // Transaction model: a queue of remaining steps, each enabled until its done is
    // seen, released until done clears, then popped; the wait step lasts WAIT_LEN cycles.
    typedef enum {K_RST, K_WR, K_WAIT, K_RD} kind_t;
    typedef struct {
        kind_t      kind;
        logic [7:0] cmd;
    } step_t;

    step_t       m_steps[$];
    step_t       m_h;
    logic        m_busy = 1'b0, m_rel = 1'b0, m_fail = 1'b0, m_perr = 1'b0, m_valid = 1'b0;
    logic [15:0] m_temp = 16'h0000;
    logic [7:0]  m_lsb, m_msb;
    int          m_wait_left;
    logic        done_in, e_rst, e_wr, e_rd;
    logic [1:0]  e_bus;
    logic        p_rst = 1'b0, p_wr = 1'b0, p_rd = 1'b0;

    function automatic step_t mk(input kind_t k, input logic [7:0] c);
        step_t s;
        s.kind = k;
        s.cmd = c;
        return s;
    endfunction

    always @(posedge clk) begin
        #1;
        m_valid = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_rel = 1'b0;
            m_fail = 1'b0;
            m_perr = 1'b0;
            m_temp = 16'h0000;
            m_steps.delete();
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1'b1;
                m_rel = 1'b0;
                m_fail = 1'b0;
                m_perr = 1'b0;
                m_lsb = cfg_lsb;
                m_msb = cfg_msb;
                m_steps = '{mk(K_RST, 8'h00), mk(K_WR, 8'hCC), mk(K_WR, 8'h44), mk(K_WAIT, 8'h00),
                            mk(K_RST, 8'h00), mk(K_WR, 8'hCC), mk(K_WR, 8'hBE), mk(K_RD, 8'h00),
                            mk(K_RD, 8'h00)};
            end
        end else begin
            m_h = m_steps[0];
            if (m_h.kind == K_WAIT) begin
                m_wait_left--;
                if (m_wait_left == 0) void'(m_steps.pop_front());
            end else begin
                done_in = (m_h.kind == K_RST) ? rst_done : (m_h.kind == K_WR) ? wr_done : rd_done;
                if (!m_rel) begin
                    if (done_in) begin
                        m_rel = 1'b1;
                        if (m_h.kind == K_RST && !rst_presence) begin
                            m_fail = 1'b1;
                            m_perr = 1'b1;
                        end
                    end
                end else if (!done_in) begin
                    void'(m_steps.pop_front());
                    m_rel = 1'b0;
                    if (m_fail) begin
                        m_busy = 1'b0;
                        m_steps.delete();
                    end else if (m_steps.size() == 0) begin
                        m_busy = 1'b0;
                        m_temp = {m_msb, m_lsb};
                        m_valid = 1'b1;
                    end else if (m_steps[0].kind == K_WAIT) begin
                        m_wait_left = WAIT_LEN;
                    end
                end
            end
        end

        e_rst = 1'b0;
        e_wr = 1'b0;
        e_rd = 1'b0;
        e_bus = 2'd0;
        if (m_busy) begin
            m_h = m_steps[0];
            case (m_h.kind)
                K_RST:   e_bus = 2'd1;
                K_WR:    e_bus = 2'd2;
                K_RD:    e_bus = 2'd3;
                default: e_bus = 2'd0;
            endcase
            e_rst = !m_rel && m_h.kind == K_RST;
            e_wr  = !m_rel && m_h.kind == K_WR;
            e_rd  = !m_rel && m_h.kind == K_RD;
        end

        chk("busy", 32'(busy), 32'(m_busy));
        chk("rst_en", 32'(rst_en), 32'(e_rst));
        chk("wr_en", 32'(wr_en), 32'(e_wr));
        chk("rd_en", 32'(rd_en), 32'(e_rd));
        chk("bus_sel", 32'(bus_sel), 32'(e_bus));
        chk("temp_valid", 32'(temp_valid), 32'(m_valid));
        chk("temp", 32'(temp), 32'(m_temp));
        chk("presence_err", 32'(presence_err), 32'(m_perr));
        if (!rst_n) chk("wr_byte_reset", 32'(wr_byte), 32'h0);
        else if (e_wr) chk("wr_byte", 32'(wr_byte), 32'(m_h.cmd));

        if ((rst_en && !p_rst) || (wr_en && !p_wr) || (rd_en && !p_rd))
            chk("en_rise_with_done", 32'({rst_done, wr_done, rd_done}), 32'h0);
        p_rst = rst_en;
        p_wr = wr_en;
        p_rd = rd_en;

        if (temp_valid) valid_cnt++;
        if (rst_n && busy && bus_sel == 2'd0 && !rst_en && !wr_en && !rd_en) begin
            wait_run++;
        end else if (wait_run > 0) begin
            last_wait = wait_run;
            wait_run = 0;
        end
    end

    task automatic run_txn(input logic [7:0] lsb, input logic [7:0] msb,
                           input logic pres, input int hold);
        int cyc;
        cfg_presence = pres;
        cfg_wr_hold = hold;
        cfg_lsb = lsb;
        cfg_msb = msb;
        rd_q.delete();
        rd_q.push_back(lsb);
        rd_q.push_back(msb);
        wr_log.delete();
        valid_cnt = 0;
        last_wait = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_accept_busy", 32'(busy), 32'h1);
        chk("start_clears_perr", 32'(presence_err), 32'h0);
        cyc = 0;
        while (busy && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = (busy && noise_en) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
        end
        start = 1'b0;
        chk("txn_finished", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp_cmds[4];
        logic [7:0] rl, rm;
        int         cyc;
        exp_cmds = '{8'hCC, 8'h44, 8'hCC, 8'hBE};
        rst_n = 1'b0;
        start = 1'b0;
        cfg_presence = 1'b1;
        cfg_wr_hold = 0;
        noise_en = 1'b0;
        cfg_lsb = 8'h00;
        cfg_msb = 8'h00;
        valid_cnt = 0;
        last_wait = 0;
        wait_run = 0;
        repeat (3) @(negedge clk);
        chk("reset_temp", 32'(temp), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_bus_sel", 32'(bus_sel), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(8'h50, 8'h05, 1'b1, 0);
        chk("t1_temp", 32'(temp), 32'h0550);
        chk("t1_valid_pulses", 32'(valid_cnt), 32'd1);
        chk("t4_wr_count", 32'(wr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("t4_wr_byte", (i < wr_log.size()) ? 32'(wr_log[i]) : 32'hFFFF, 32'(exp_cmds[i]));
        chk("t4_wait_len", 32'(last_wait), 32'd54);

        run_txn(8'h12, 8'h34, 1'b0, 0);
        chk("t2_presence_err", 32'(presence_err), 32'h1);
        chk("t2_no_wr", 32'(wr_log.size()), 32'd0);
        chk("t2_no_valid", 32'(valid_cnt), 32'd0);
        chk("t2_temp_held", 32'(temp), 32'h0550);

        run_txn(8'hA5, 8'h5A, 1'b1, 5);
        chk("t3_temp", 32'(temp), 32'h5AA5);
        chk("t3_wr_count", 32'(wr_log.size()), 32'd4);

        noise_en = 1'b1;
        run_txn(8'h81, 8'h7E, 1'b1, 2);
        chk("t6_temp", 32'(temp), 32'h7E81);
        chk("t6_valid_pulses", 32'(valid_cnt), 32'd1);
        chk("t6_wait_len", 32'(last_wait), 32'd54);
        noise_en = 1'b0;

        cfg_presence = 1'b1;
        cfg_wr_hold = 0;
        cfg_lsb = 8'hDE;
        cfg_msb = 8'hAD;
        rd_q.delete();
        rd_q.push_back(8'hDE);
        rd_q.push_back(8'hAD);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!rd_en && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("t5_reached_rdlsb", 32'(rd_en), 32'h1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_enables", 32'({rst_en, wr_en, rd_en}), 32'h0);
        chk("t5_bus_sel", 32'(bus_sel), 32'h0);
        chk("t5_temp", 32'(temp), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_txn(8'h3C, 8'hC3, 1'b1, 0);
        chk("t5_fresh_temp", 32'(temp), 32'hC33C);

        for (int t = 0; t < 4; t++) begin
            rl = 8'($urandom);
            rm = 8'($urandom);
            noise_en = 1'($urandom_range(0, 1));
            run_txn(rl, rm, 1'b1, $urandom_range(0, 5));
            chk("rand_temp", 32'(temp), 32'({rm, rl}));
            chk("rand_valid_pulses", 32'(valid_cnt), 32'd1);
        end
        noise_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
